// File: rtl/rau_alloc_ctrl.sv
// Warp-slot allocation controller: tracks HW warp occupancy, serialises RAU
// allocate/deallocate commands (exits before launches) and pulses the scheduler.
module rau_alloc_ctrl #(
  parameter int NUM_WARPS = 8,
  parameter int SW_W      = 8,
  parameter int AVAIL_W   = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_valid,
  output logic                 launch_ready,
  input  logic [SW_W-1:0]      launch_sw_warp,
  input  logic [2:0]           launch_nreq,
  input  logic                 exit_valid,
  input  logic [2:0]           exit_warp,
  output logic                 allo_en,
  output logic [2:0]           allo_nreq,
  output logic [2:0]           allo_hw_warp,
  output logic [SW_W-1:0]      allo_sw_warp,
  output logic                 dealloc_en,
  output logic [2:0]           dealloc_warp,
  input  logic                 req_done,
  input  logic [AVAIL_W-1:0]   available,
  output logic                 start_valid,
  output logic [2:0]           start_hw_warp,
  output logic [SW_W-1:0]      start_sw_warp,
  output logic [NUM_WARPS-1:0] busy_mask,
  output logic                 err_timeout,
  output logic                 err_bad_exit
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEALLO,
    S_ALLO,
    S_WAIT,
    S_SETTLE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_WARPS-1:0]   busy_q, busy_d;
  logic [NUM_WARPS-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             nreq_q, nreq_d;
  logic [2:0]             hw_q, hw_d;
  logic [SW_W-1:0]        sw_q, sw_d;
  logic [2:0]             dwarp_q, dwarp_d;
  logic                   sv_q, sv_d;
  logic [2:0]             shw_q, shw_d;
  logic [SW_W-1:0]        ssw_q, ssw_d;
  logic                   eto_q, eto_d;
  logic                   ebe_q, ebe_d;

  logic [3:0]             need;
  logic                   regs_ok;
  logic                   free_found;
  logic [2:0]             free_idx;
  logic [2:0]             pend_idx;
  logic                   exit_hit;

  // Odd requests round up to the next even register count.
  assign need     = {1'b0, launch_nreq} + {3'b000, launch_nreq[0]};
  assign regs_ok  = ({{AVAIL_W{1'b0}}, need} <= {4'b0000, available});
  assign exit_hit = exit_valid && busy_q[exit_warp];

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_idx   = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (pend_q[i]) begin
        pend_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;
    nreq_d       = nreq_q;
    hw_d         = hw_q;
    sw_d         = sw_q;
    dwarp_d      = dwarp_q;
    sv_d         = 1'b0;
    shw_d        = shw_q;
    ssw_d        = ssw_q;
    eto_d        = eto_q;
    ebe_d        = ebe_q;
    launch_ready = 1'b0;
    allo_en      = 1'b0;
    dealloc_en   = 1'b0;

    if (exit_valid) begin
      if (busy_q[exit_warp]) pend_d[exit_warp] = 1'b1;
      else                   ebe_d             = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          dwarp_d = pend_idx;
          state_d = S_DEALLO;
        end else if (!rst && !exit_hit && launch_valid && free_found && regs_ok) begin
          // An exit captured this cycle pre-empts the launch.
          launch_ready = 1'b1;
          nreq_d       = launch_nreq;
          hw_d         = free_idx;
          sw_d         = launch_sw_warp;
          state_d      = S_ALLO;
        end
      end
      S_DEALLO: begin
        dealloc_en      = 1'b1;
        busy_d[dwarp_q] = 1'b0;
        pend_d[dwarp_q] = 1'b0;
        state_d         = S_SETTLE;
      end
      S_ALLO: begin
        allo_en      = 1'b1;
        busy_d[hw_q] = 1'b1;
        cnt_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (req_done) begin
          sv_d    = 1'b1;
          shw_d   = hw_q;
          ssw_d   = sw_q;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          eto_d        = 1'b1;
          busy_d[hw_q] = 1'b0;
          state_d      = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      nreq_q  <= '0;
      hw_q    <= '0;
      sw_q    <= '0;
      dwarp_q <= '0;
      sv_q    <= 1'b0;
      shw_q   <= '0;
      ssw_q   <= '0;
      eto_q   <= 1'b0;
      ebe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      nreq_q  <= nreq_d;
      hw_q    <= hw_d;
      sw_q    <= sw_d;
      dwarp_q <= dwarp_d;
      sv_q    <= sv_d;
      shw_q   <= shw_d;
      ssw_q   <= ssw_d;
      eto_q   <= eto_d;
      ebe_q   <= ebe_d;
    end
  end

  assign allo_nreq     = nreq_q;
  assign allo_hw_warp  = hw_q;
  assign allo_sw_warp  = sw_q;
  assign dealloc_warp  = dwarp_q;
  assign start_valid   = sv_q;
  assign start_hw_warp = shw_q;
  assign start_sw_warp = ssw_q;
  assign busy_mask     = busy_q;
  assign err_timeout   = eto_q;
  assign err_bad_exit  = ebe_q;

endmodule

// File: tb/tb_rau_alloc_ctrl.sv
// Bench for rau_alloc_ctrl: sufficiency table, directed corner sequences and
// random traffic, all shadowed cycle by cycle by a slot/operation-age model.
module tb_rau_alloc_ctrl;

  localparam int TIMEOUT = 64;

  logic       clk;
  logic       rst;
  logic       launch_valid;
  logic       launch_ready;
  logic [7:0] launch_sw_warp;
  logic [2:0] launch_nreq;
  logic       exit_valid;
  logic [2:0] exit_warp;
  logic       allo_en;
  logic [2:0] allo_nreq;
  logic [2:0] allo_hw_warp;
  logic [7:0] allo_sw_warp;
  logic       dealloc_en;
  logic [2:0] dealloc_warp;
  logic       req_done;
  logic [4:0] available;
  logic       start_valid;
  logic [2:0] start_hw_warp;
  logic [7:0] start_sw_warp;
  logic [7:0] busy_mask;
  logic       err_timeout;
  logic       err_bad_exit;

  rau_alloc_ctrl #(.NUM_WARPS(8), .SW_W(8), .AVAIL_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_sw_warp(launch_sw_warp), .launch_nreq(launch_nreq),
    .exit_valid(exit_valid), .exit_warp(exit_warp),
    .allo_en(allo_en), .allo_nreq(allo_nreq), .allo_hw_warp(allo_hw_warp),
    .allo_sw_warp(allo_sw_warp),
    .dealloc_en(dealloc_en), .dealloc_warp(dealloc_warp),
    .req_done(req_done), .available(available),
    .start_valid(start_valid), .start_hw_warp(start_hw_warp),
    .start_sw_warp(start_sw_warp),
    .busy_mask(busy_mask), .err_timeout(err_timeout), .err_bad_exit(err_bad_exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [41:0] act_vec();
    return {launch_ready, allo_en, allo_nreq, allo_hw_warp, allo_sw_warp,
            dealloc_en, dealloc_warp, start_valid, start_hw_warp, start_sw_warp,
            busy_mask, err_timeout, err_bad_exit};
  endfunction

  // Reference model: occupied/pending slot sets plus the current operation
  // (0 none, 1 free a slot, 2 fill a slot) and how many cycles it has run.
  logic [7:0] m_busy, m_pend;
  int         m_op, m_age;
  bit         m_settle;
  logic [2:0] m_nreq, m_hw, m_dw, m_shw;
  logic [7:0] m_sw, m_ssw;
  bit         m_sv, m_eto, m_ebe;

  task automatic model_reset();
    m_busy = '0; m_pend = '0; m_op = 0; m_age = 0; m_settle = 0;
    m_nreq = '0; m_hw = '0; m_dw = '0; m_shw = '0; m_sw = '0; m_ssw = '0;
    m_sv = 0; m_eto = 0; m_ebe = 0;
  endtask

  function automatic int lowest_set(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    int         need;
    bit         idle_now, hit, ready, sv;
    logic [7:0] new_pend;
    #1;
    need     = int'(launch_nreq) + (int'(launch_nreq) % 2);
    idle_now = (m_op == 0) && !m_settle;
    hit      = exit_valid && m_busy[exit_warp];
    ready    = !rst && idle_now && (m_pend == 0) && !hit && launch_valid &&
               (m_busy != 8'hFF) && (need <= int'(available));
    chk("cycle_outputs", act_vec(),
        {ready, (m_op == 2 && m_age == 0), m_nreq, m_hw, m_sw,
         (m_op == 1), m_dw, m_sv, m_shw, m_ssw, m_busy, m_eto, m_ebe});
    if (rst) begin
      model_reset();
    end else begin
      new_pend = m_pend;
      sv = 0;
      if (exit_valid) begin
        if (m_busy[exit_warp]) new_pend[exit_warp] = 1'b1;
        else m_ebe = 1;
      end
      if (m_settle) begin
        m_settle = 0;
      end else if (m_op == 0) begin
        if (m_pend != 0) begin
          m_dw = 3'(lowest_set(m_pend));
          m_op = 1;
        end else if (ready) begin
          m_hw = 3'(lowest_set(~m_busy));
          m_nreq = launch_nreq;
          m_sw = launch_sw_warp;
          m_op = 2;
          m_age = 0;
        end
      end else if (m_op == 1) begin
        m_busy[m_dw] = 1'b0;
        new_pend[m_dw] = 1'b0;
        m_op = 0;
        m_settle = 1;
      end else begin
        if (m_age == 0) begin
          m_busy[m_hw] = 1'b1;
          m_age = 1;
        end else if (req_done) begin
          sv = 1; m_shw = m_hw; m_ssw = m_sw;
          m_op = 0; m_settle = 1;
        end else if (m_age == TIMEOUT) begin
          m_eto = 1; m_busy[m_hw] = 1'b0;
          m_op = 0; m_settle = 1;
        end else begin
          m_age++;
        end
      end
      m_pend = new_pend;
      m_sv = sv;
    end
    @(posedge clk);
    #1;
  endtask

  // Launch from IDLE and complete it with req_done in the first WAIT cycle.
  task automatic launch(input logic [2:0] nreq, input logic [7:0] sw,
                        output logic rdy, output logic [2:0] hw);
    launch_valid = 1'b1; launch_nreq = nreq; launch_sw_warp = sw;
    #1 rdy = launch_ready;
    tick();
    launch_valid = 1'b0;
    #1 hw = allo_hw_warp;
    tick();
    req_done = 1'b1; tick();
    req_done = 1'b0; tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] nreq;
    logic [4:0] avail;
    bit         ready;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic       rdy;
    logic [2:0] hw;
    int         k;
    bit         saw_start;

    vecs[0]  = '{3'd0, 5'd0,  1'b1};
    vecs[1]  = '{3'd1, 5'd1,  1'b0};
    vecs[2]  = '{3'd1, 5'd2,  1'b1};
    vecs[3]  = '{3'd2, 5'd2,  1'b1};
    vecs[4]  = '{3'd2, 5'd1,  1'b0};
    vecs[5]  = '{3'd3, 5'd3,  1'b0};
    vecs[6]  = '{3'd3, 5'd4,  1'b1};
    vecs[7]  = '{3'd4, 5'd4,  1'b1};
    vecs[8]  = '{3'd5, 5'd5,  1'b0};
    vecs[9]  = '{3'd5, 5'd6,  1'b1};
    vecs[10] = '{3'd7, 5'd7,  1'b0};
    vecs[11] = '{3'd7, 5'd8,  1'b1};
    vecs[12] = '{3'd6, 5'd31, 1'b1};
    vecs[13] = '{3'd7, 5'd31, 1'b1};

    rst = 1'b1; launch_valid = 0; launch_sw_warp = 0; launch_nreq = 0;
    exit_valid = 0; exit_warp = 0; req_done = 0; available = 5'd16;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    #1 chk("reset_outputs", act_vec(), 42'd0);
    rst = 1'b0;

    // Basic launch and completion.
    launch_valid = 1; launch_nreq = 3'd3; launch_sw_warp = 8'h21;
    #1 chk("t1_launch_ready", launch_ready, 1);
    tick();
    launch_valid = 0;
    #1 chk("t1_allo", {allo_en, allo_nreq, allo_hw_warp, allo_sw_warp}, {1'b1, 3'd3, 3'd0, 8'h21});
    tick();
    tick();
    req_done = 1; tick(); req_done = 0;
    #1 chk("t1_start", {start_valid, start_hw_warp, start_sw_warp}, {1'b1, 3'd0, 8'h21});
    chk("t1_busy", busy_mask, 8'h01);
    tick();

    // Exit and launch in the same cycle: exit served first.
    launch_valid = 1; launch_nreq = 3'd1; launch_sw_warp = 8'h42;
    exit_valid = 1; exit_warp = 3'd0;
    #1 chk("t2_ready_blocked", launch_ready, 0);
    tick();
    exit_valid = 0;
    #1 chk("t2_ready_pend", launch_ready, 0);
    tick();
    #1 chk("t2_dealloc", {dealloc_en, dealloc_warp, launch_ready}, {1'b1, 3'd0, 1'b0});
    tick();
    #1 chk("t2_settle", {launch_ready, busy_mask}, {1'b0, 8'h00});
    tick();
    launch(3'd1, 8'h42, rdy, hw);
    chk("t2_ready_after", rdy, 1);
    chk("t2_hw", hw, 0);

    // Insufficient registers until available rises.
    available = 5'd2; launch_valid = 1; launch_nreq = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_ready_low", launch_ready, 0);
      tick();
    end
    available = 5'd4;
    launch(3'd3, 8'h13, rdy, hw);
    chk("t3_ready_ok", rdy, 1);
    chk("t3_hw", hw, 1);
    available = 5'd16;

    // Fill all slots, then free slot 5 and reuse it.
    for (int i = 2; i < 8; i++) begin
      launch(3'd2, 8'(8'h80 + i), rdy, hw);
      chk("t4_fill_hw", hw, i);
    end
    #1 chk("t4_busy_full", busy_mask, 8'hFF);
    launch_valid = 1; launch_nreq = 3'd1;
    #1 chk("t4_ready_full", launch_ready, 0);
    tick();
    launch_valid = 0;
    exit_valid = 1; exit_warp = 3'd5; tick();
    exit_valid = 0; tick();
    #1 chk("t4_dealloc5", {dealloc_en, dealloc_warp}, {1'b1, 3'd5});
    tick();
    tick();
    launch(3'd2, 8'h55, rdy, hw);
    chk("t4_reuse_hw", hw, 5);

    // Exit for a non-busy slot.
    do_reset();
    exit_valid = 1; exit_warp = 3'd3; tick();
    exit_valid = 0;
    #1 chk("t5_bad_exit", err_bad_exit, 1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_no_dealloc", dealloc_en, 0);
      tick();
    end

    // req_done never arrives.
    do_reset();
    launch_valid = 1; launch_nreq = 3'd2; launch_sw_warp = 8'h77; tick();
    launch_valid = 0;
    #1 chk("t6_allo", allo_en, 1);
    tick();
    k = 0; saw_start = 0;
    while (k < 200) begin
      #1;
      if (err_timeout) break;
      if (start_valid) saw_start = 1;
      tick();
      k++;
    end
    chk("t6_wait_cycles", k, TIMEOUT);
    chk("t6_no_start", {saw_start, start_valid}, 2'b00);
    chk("t6_busy_clr", busy_mask, 8'h00);
    tick();

    // Reset in the middle of WAIT.
    launch_valid = 1; tick();
    launch_valid = 0; tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1; tick();
    #1 chk("t7_reset_midwait", act_vec(), 42'd0);
    rst = 0; tick();

    // Register sufficiency table, each from a fresh reset.
    foreach (vecs[i]) begin
      do_reset();
      available = vecs[i].avail; launch_valid = 1; launch_nreq = vecs[i].nreq;
      launch_sw_warp = 8'(i);
      #1 chk("tbl_ready", launch_ready, vecs[i].ready);
      tick();
      launch_valid = 0;
      if (vecs[i].ready) begin
        #1 chk("tbl_allo_nreq", {allo_en, allo_nreq}, {1'b1, vecs[i].nreq});
        tick();
        req_done = 1; tick();
        req_done = 0; tick();
      end
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      launch_valid   = $urandom_range(0, 1) == 1;
      launch_nreq    = 3'($urandom_range(0, 7));
      launch_sw_warp = 8'($urandom);
      available      = 5'($urandom_range(0, 20));
      exit_valid     = ($urandom_range(0, 5) == 0);
      exit_warp      = 3'($urandom_range(0, 7));
      req_done       = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 0; launch_valid = 0; exit_valid = 0; req_done = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
